sram_access_arbiter: RTL and testbench

Shares the single-port SRAM controller among four requesters: UART receive (0), Milestone 1 (1), Milestone 2 (2) and VGA fetch (3). It replaces the top-level state-based address/data/we_n mux with an explicit req/grant protocol. It bounds each ownership to a burst length and tags in-flight reads so returned data reaches the owner that issued them. It sits between the requester units and SRAM_Controller in the top module.

---
 rtl/sram_access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Arbitrates four requesters onto one SRAM controller with a req/grant handshake,
// bounded bursts, and read-return tagging so data reaches the requester that issued it.
module sram_access_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_BURST    = 256
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Req,
    input  logic [3:0][17:0] Req_address,
    input  logic [3:0][15:0] Req_write_data,
    input  logic [3:0]       Req_we_n,
    output logic [3:0]       Grant,
    output logic [3:0]       Rd_valid,
    output logic [17:0]      SRAM_address,
    output logic [15:0]      SRAM_write_data,
    output logic             SRAM_we_n,
    output logic             Busy,
    output logic [1:0]       Owner
);

    localparam int unsigned BurstW = $clog2(MAX_BURST);
    localparam int unsigned DrainW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StDrain} state_e;

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                rr_q, rr_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [17:0]         addr_q;
    logic [15:0]         wdata_q;

    logic [READ_LATENCY-1:0]      tag_vld_q;
    logic [READ_LATENCY-1:0][1:0] tag_own_q;

    logic [3:0] owner_oh;
    logic       owner_req;
    logic       others_req;
    logic       access;
    logic       push;
    logic [1:0] start;
    logic [1:0] idx;
    logic [1:0] winner;
    logic       found;

    assign owner_oh   = 4'b0001 << owner_q;
    assign owner_req  = Req[owner_q];
    assign others_req = |(Req & ~owner_oh);
    // An owned cycle with Req low is not an access: no bus drive, no read tag.
    assign access     = (state_q == StOwn) && owner_req;
    assign push       = access && Req_we_n[owner_q];

    // Search starts at 0 after reset/voluntary release, at Owner+1 after a burst expiry.
    always_comb begin
        start  = rr_q ? (owner_q + 2'd1) : 2'd0;
        winner = start;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && Req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (|Req) begin
                    owner_d = winner;
                    burst_d = '0;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (!owner_req) begin
                    state_d = StDrain;
                    drain_d = '0;
                    burst_d = '0;
                    rr_d    = 1'b0;
                end else if (burst_q == BurstLast) begin
                    burst_d = '0;
                    if (others_req) begin
                        state_d = StDrain;
                        drain_d = '0;
                        rr_d    = 1'b1;
                    end
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            rr_q    <= 1'b0;
            burst_q <= '0;
            drain_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            drain_q <= drain_d;
            if (access) begin
                addr_q  <= Req_address[owner_q];
                wdata_q <= Req_write_data[owner_q];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q[0] <= push;
            tag_own_q[0] <= owner_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    always_comb begin
        Grant           = (state_q == StOwn) ? owner_oh : 4'b0000;
        SRAM_address    = access ? Req_address[owner_q] : addr_q;
        SRAM_write_data = access ? Req_write_data[owner_q] : wdata_q;
        SRAM_we_n       = access ? Req_we_n[owner_q] : 1'b1;
        Rd_valid        = tag_vld_q[READ_LATENCY-1] ?
                          (4'b0001 << tag_own_q[READ_LATENCY-1]) : 4'b0000;
        Busy            = (state_q != StIdle);
        Owner           = owner_q;
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: a vector table for grant/read/write sequencing plus hand-written
// sequences for burst expiry, simultaneous release/request and mid-burst reset.
module tb_sram_access_arbiter;

    logic             Clock;
    logic             Reset;
    logic [3:0]       Req;
    logic [3:0][17:0] Req_address;
    logic [3:0][15:0] Req_write_data;
    logic [3:0]       Req_we_n;
    logic [3:0]       Grant;
    logic [3:0]       Rd_valid;
    logic [17:0]      SRAM_address;
    logic [15:0]      SRAM_write_data;
    logic             SRAM_we_n;
    logic             Busy;
    logic [1:0]       Owner;

    int checks = 0;
    int failures = 0;
    int grant_viol = 0;

    sram_access_arbiter #(
        .READ_LATENCY(2),
        .MAX_BURST   (4)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Req            (Req),
        .Req_address    (Req_address),
        .Req_write_data (Req_write_data),
        .Req_we_n       (Req_we_n),
        .Grant          (Grant),
        .Rd_valid       (Rd_valid),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .Busy           (Busy),
        .Owner          (Owner)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (!$onehot0(Grant)) grant_viol++;
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we_n;
        logic [17:0] addr;
        logic [15:0] wd;
        logic [3:0]  grant;
        logic [3:0]  rd;
        logic        we;
        logic [17:0] sa;
        logic [15:0] sd;
        logic        busy;
        logic [1:0]  own;
    } vec_t;

    vec_t tbl [26];

    // Grant traces for the burst-expiry runs (MAX_BURST=4, READ_LATENCY=2).
    logic [3:0] exp_b1 [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0,
                                4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [3:0] exp_b2 [9]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2};
    logic [3:0] exp_e_g [7] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4};
    logic       exp_e_b [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] req_e   [7] = '{4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we_n,
                                input logic [17:0] addr, input logic [15:0] wd,
                                input logic [3:0] grant, input logic [3:0] rd,
                                input logic we, input logic [17:0] sa,
                                input logic [15:0] sd, input logic busy,
                                input logic [1:0] own);
        vec_t v;
        v.req = req; v.we_n = we_n; v.addr = addr; v.wd = wd;
        v.grant = grant; v.rd = rd; v.we = we; v.sa = sa; v.sd = sd;
        v.busy = busy; v.own = own;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester i sees address addr | i<<16 and data wd ^ i<<12, so the mux choice is visible.
    task automatic drive(input logic [3:0] req, input logic [3:0] we_n,
                         input logic [17:0] addr, input logic [15:0] wd);
        Req      = req;
        Req_we_n = we_n;
        for (int i = 0; i < 4; i++) begin
            Req_address[i]    = addr | (18'(i) << 16);
            Req_write_data[i] = wd ^ (16'(i) << 12);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(4'h0, 4'hF, 18'h0, 16'h0);
            next_cycle();
        end
    endtask

    initial begin
        // Grant 1 of 1010, release, then 3; requester 2 reads; requester 0 writes.
        tbl[0]  = mk(4'b1010, 4'hF, 18'h10, 16'h0, 4'h0, 4'h0, 1, 18'h00000, 16'h0000, 0, 0);
        tbl[1]  = mk(4'b1010, 4'hF, 18'h10, 16'h0, 4'h2, 4'h0, 1, 18'h10010, 16'h1000, 1, 1);
        tbl[2]  = mk(4'b1010, 4'hF, 18'h11, 16'h0, 4'h2, 4'h0, 1, 18'h10011, 16'h1000, 1, 1);
        tbl[3]  = mk(4'b1000, 4'hF, 18'h11, 16'h0, 4'h2, 4'h2, 1, 18'h10011, 16'h1000, 1, 1);
        tbl[4]  = mk(4'b1000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h2, 1, 18'h10011, 16'h1000, 1, 1);
        tbl[5]  = mk(4'b1000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h0, 1, 18'h10011, 16'h1000, 1, 1);
        tbl[6]  = mk(4'b1000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h0, 1, 18'h10011, 16'h1000, 0, 1);
        tbl[7]  = mk(4'b1000, 4'hF, 18'h20, 16'h0, 4'h8, 4'h0, 1, 18'h30020, 16'h3000, 1, 3);
        tbl[8]  = mk(4'b0000, 4'hF, 18'h20, 16'h0, 4'h8, 4'h0, 1, 18'h30020, 16'h3000, 1, 3);
        tbl[9]  = mk(4'b0000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h8, 1, 18'h30020, 16'h3000, 1, 3);
        tbl[10] = mk(4'b0000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h0, 1, 18'h30020, 16'h3000, 1, 3);
        tbl[11] = mk(4'b0000, 4'hF, 18'h20, 16'h0, 4'h0, 4'h0, 1, 18'h30020, 16'h3000, 0, 3);
        tbl[12] = mk(4'b0100, 4'hF, 18'd100, 16'h0, 4'h0, 4'h0, 1, 18'h30020, 16'h3000, 0, 3);
        tbl[13] = mk(4'b0100, 4'hF, 18'd100, 16'h0, 4'h4, 4'h0, 1, 18'h20064, 16'h2000, 1, 2);
        tbl[14] = mk(4'b0100, 4'hF, 18'd101, 16'h0, 4'h4, 4'h0, 1, 18'h20065, 16'h2000, 1, 2);
        tbl[15] = mk(4'b0100, 4'hF, 18'd102, 16'h0, 4'h4, 4'h4, 1, 18'h20066, 16'h2000, 1, 2);
        tbl[16] = mk(4'b0000, 4'hF, 18'd102, 16'h0, 4'h4, 4'h4, 1, 18'h20066, 16'h2000, 1, 2);
        tbl[17] = mk(4'b0000, 4'hF, 18'd102, 16'h0, 4'h0, 4'h4, 1, 18'h20066, 16'h2000, 1, 2);
        tbl[18] = mk(4'b0000, 4'hF, 18'd102, 16'h0, 4'h0, 4'h0, 1, 18'h20066, 16'h2000, 1, 2);
        tbl[19] = mk(4'b0000, 4'hF, 18'd102, 16'h0, 4'h0, 4'h0, 1, 18'h20066, 16'h2000, 0, 2);
        tbl[20] = mk(4'b0001, 4'hE, 18'h10, 16'hABCD, 4'h0, 4'h0, 1, 18'h20066, 16'h2000, 0, 2);
        tbl[21] = mk(4'b0001, 4'hE, 18'h10, 16'hABCD, 4'h1, 4'h0, 0, 18'h00010, 16'hABCD, 1, 0);
        tbl[22] = mk(4'b0000, 4'hF, 18'h10, 16'h0, 4'h1, 4'h0, 1, 18'h00010, 16'hABCD, 1, 0);
        tbl[23] = mk(4'b0000, 4'hF, 18'h10, 16'h0, 4'h0, 4'h0, 1, 18'h00010, 16'hABCD, 1, 0);
        tbl[24] = mk(4'b0000, 4'hF, 18'h10, 16'h0, 4'h0, 4'h0, 1, 18'h00010, 16'hABCD, 1, 0);
        tbl[25] = mk(4'b0000, 4'hF, 18'h10, 16'h0, 4'h0, 4'h0, 1, 18'h00010, 16'hABCD, 0, 0);

        Reset = 1'b1;
        drive(4'h0, 4'hF, 18'h0, 16'h0);
        repeat (2) @(posedge Clock);
        #2;
        check("rst_grant", 32'(Grant), 32'h0);
        check("rst_rd_valid", 32'(Rd_valid), 32'h0);
        check("rst_we_n", 32'(SRAM_we_n), 32'h1);
        check("rst_addr", 32'(SRAM_address), 32'h0);
        check("rst_wdata", 32'(SRAM_write_data), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_owner", 32'(Owner), 32'h0);
        Reset = 1'b0;

        for (int k = 0; k < 26; k++) begin
            drive(tbl[k].req, tbl[k].we_n, tbl[k].addr, tbl[k].wd);
            @(negedge Clock);
            check($sformatf("v%0d_grant", k), 32'(Grant), 32'(tbl[k].grant));
            check($sformatf("v%0d_rd_valid", k), 32'(Rd_valid), 32'(tbl[k].rd));
            check($sformatf("v%0d_we_n", k), 32'(SRAM_we_n), 32'(tbl[k].we));
            check($sformatf("v%0d_addr", k), 32'(SRAM_address), 32'(tbl[k].sa));
            check($sformatf("v%0d_wdata", k), 32'(SRAM_write_data), 32'(tbl[k].sd));
            check($sformatf("v%0d_busy", k), 32'(Busy), 32'(tbl[k].busy));
            check($sformatf("v%0d_owner", k), 32'(Owner), 32'(tbl[k].own));
            next_cycle();
        end

        // Burst expiry: 0 and 3 contend, 0 wins first, then round-robin alternates.
        for (int c = 0; c < 16; c++) begin
            drive(4'b1001, 4'hF, 18'h0, 16'h0);
            @(negedge Clock);
            check($sformatf("burst1_c%0d_grant", c), 32'(Grant), 32'(exp_b1[c]));
            next_cycle();
        end
        idle_cycles(5);

        // With 1 also pending, the search from Owner+1 reaches 1 before 3.
        for (int c = 0; c < 9; c++) begin
            drive(4'b1011, 4'hF, 18'h0, 16'h0);
            @(negedge Clock);
            check($sformatf("burst2_c%0d_grant", c), 32'(Grant), 32'(exp_b2[c]));
            next_cycle();
        end
        idle_cycles(5);

        // Owner releases in the same cycle another request rises.
        for (int c = 0; c < 7; c++) begin
            drive(req_e[c], 4'hF, 18'h0, 16'h0);
            @(negedge Clock);
            check($sformatf("handoff_c%0d_grant", c), 32'(Grant), 32'(exp_e_g[c]));
            check($sformatf("handoff_c%0d_busy", c), 32'(Busy), 32'(exp_e_b[c]));
            next_cycle();
        end
        idle_cycles(5);

        // Reset while requester 1 owns the bus with reads in flight.
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 4'hF, 18'h40, 16'h0);
            @(negedge Clock);
            if (c > 0) check($sformatf("rstmid_c%0d_grant", c), 32'(Grant), 32'h2);
            if (c < 2) next_cycle();
        end
        #2;
        Reset = 1'b1;
        #1;
        check("rstmid_grant", 32'(Grant), 32'h0);
        check("rstmid_rd_valid", 32'(Rd_valid), 32'h0);
        check("rstmid_we_n", 32'(SRAM_we_n), 32'h1);
        check("rstmid_addr", 32'(SRAM_address), 32'h0);
        check("rstmid_busy", 32'(Busy), 32'h0);
        check("rstmid_owner", 32'(Owner), 32'h0);
        drive(4'h0, 4'hF, 18'h0, 16'h0);
        next_cycle();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            check($sformatf("postrst_c%0d_rd_valid", c), 32'(Rd_valid), 32'h0);
            check($sformatf("postrst_c%0d_grant", c), 32'(Grant), 32'h0);
            next_cycle();
        end

        check("grant_onehot0_violations", 32'(grant_viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
